// File: rtl/rv32_seq_pkg.sv
// rv32_seq_pkg: shared states, mcause codes and constants for the core sequencer
package rv32_seq_pkg;
   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_TRAP,
      S_HALT
   } state_t;
   localparam logic [3:0] CAUSE_MISALIGN = 4'd0;
   localparam logic [3:0] CAUSE_IFAULT   = 4'd1;
   localparam logic [3:0] CAUSE_ILLEGAL  = 4'd2;
   localparam logic [3:0] CAUSE_LFAULT   = 4'd5;
   localparam logic [3:0] CAUSE_SFAULT   = 4'd7;
   localparam logic [3:0] CAUSE_ECALL    = 4'd11;
   localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
endpackage

// File: rtl/rv32_ack_watchdog.sv
// rv32_ack_watchdog: counts cycles spent waiting for a bus ack and flags a timeout
module rv32_ack_watchdog #(
   parameter int ACK_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic active_i,
   output logic timeout_o
);
   localparam int W = $clog2(ACK_TIMEOUT) + 1;
   logic [W-1:0] cnt_q, cnt_d;
   // count while waiting, restart from zero whenever the wait state is left
   always_comb cnt_d = active_i ? cnt_q + W'(1) : '0;
   // counter register
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
   assign timeout_o = active_i && (cnt_q == W'(ACK_TIMEOUT - 1));
endmodule

// File: rtl/rv32_core_sequencer.sv
// rv32_core_sequencer: multi-cycle fetch/decode/exec/mem/wb control FSM for the rv32im core
module rv32_core_sequencer
   import rv32_seq_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
   parameter int          ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] instr_o,
   input  logic        illegal_i,
   input  logic        ecall_i,
   input  logic        ebreak_i,
   input  logic        is_branch_i,
   input  logic        is_condition_i,
   input  logic        branch_taken_i,
   input  logic [31:0] target_i,
   input  logic        mem_access_i,
   input  logic        mem_w_i,
   input  logic        reg_w_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   input  logic        dmem_ack_i,
   output logic        rf_we_o,
   output logic [31:0] pc_o,
   output logic [31:0] epc_o,
   output logic        trap_o,
   output logic [3:0]  trap_cause_o,
   output logic        halt_o,
   output logic [31:0] instret_o
);
   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, instr_q, instr_d, epc_q, epc_d, instret_q, instret_d;
   logic [3:0]  cause_q, cause_d;
   logic        i_to, d_to, taken;

   rv32_ack_watchdog #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_iwd (
      .clk(clk), .rst(rst), .active_i(state_q == S_FETCH), .timeout_o(i_to)
   );
   rv32_ack_watchdog #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_dwd (
      .clk(clk), .rst(rst), .active_i(state_q == S_MEM), .timeout_o(d_to)
   );

   assign taken = is_branch_i & (~is_condition_i | branch_taken_i);

   // next-state and architectural updates; the trap cause is recorded on entry to TRAP
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      epc_d     = epc_q;
      cause_d   = cause_q;
      instret_d = instret_q;
      case (state_q)
         S_FETCH: begin
            if (imem_ack_i) begin
               instr_d = imem_rdata_i;
               state_d = S_DECODE;
            end else if (i_to) begin
               cause_d = CAUSE_IFAULT;
               state_d = S_TRAP;
            end
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            if (illegal_i) begin
               cause_d = CAUSE_ILLEGAL;
               state_d = S_TRAP;
            end else if (ecall_i) begin
               cause_d = CAUSE_ECALL;
               state_d = S_TRAP;
            end else if (ebreak_i) begin
               state_d = S_HALT;
            end else if (taken && target_i[1:0] != 2'b00) begin
               cause_d = CAUSE_MISALIGN;
               state_d = S_TRAP;
            end else begin
               state_d = mem_access_i ? S_MEM : S_WB;
            end
         end
         S_MEM: begin
            if (dmem_ack_i) begin
               state_d = S_WB;
            end else if (d_to) begin
               cause_d = mem_w_i ? CAUSE_SFAULT : CAUSE_LFAULT;
               state_d = S_TRAP;
            end
         end
         S_WB: begin
            pc_d      = taken ? target_i : pc_q + 32'd4;
            instret_d = instret_q + 32'd1;
            state_d   = S_FETCH;
         end
         S_TRAP: begin
            epc_d   = pc_q;
            pc_d    = TRAP_VECTOR;
            state_d = S_FETCH;
         end
         default: state_d = S_HALT;
      endcase
   end

   // state and architectural registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_PC;
         instr_q   <= NOP_INSTR;
         epc_q     <= '0;
         cause_q   <= '0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         epc_q     <= epc_d;
         cause_q   <= cause_d;
         instret_q <= instret_d;
      end
   end

   assign imem_req_o   = !rst && state_q == S_FETCH;
   assign dmem_req_o   = !rst && state_q == S_MEM;
   assign dmem_we_o    = dmem_req_o && mem_w_i;
   assign rf_we_o      = !rst && state_q == S_WB && reg_w_i;
   assign trap_o       = !rst && state_q == S_TRAP;
   assign halt_o       = state_q == S_HALT;
   assign imem_addr_o  = pc_q;
   assign pc_o         = pc_q;
   assign instr_o      = instr_q;
   assign epc_o        = epc_q;
   assign trap_cause_o = cause_q;
   assign instret_o    = instret_q;
endmodule
